// File: rtl/store_buffer.sv
// Posted-write store buffer: lane-aligns stores, queues them in order, drains
// them to the data-memory port over req/ack and flags loads to pending words.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_byte_en,
    output logic             sb_full,
    output logic             sb_empty,
    output logic [PTR_W:0]   sb_count,
    output logic             dm_req,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic [3:0]       dm_be,
    output logic             dm_we,
    input  logic             dm_ack,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic             push;
    logic             pop;
    logic [31:0]      wdata_aligned;
    logic             word_hit;
    logic [PTR_W-1:0] offs;
    logic             unused_ld_offset;

    assign sb_count = count;
    assign sb_full  = (count == FULL_CNT);
    assign sb_empty = (count == '0);

    assign push = st_valid && !sb_full && (st_byte_en != 4'b0000);
    assign pop  = dm_req && dm_ack;

    // Full-word stores keep their data unshifted even when the address is misaligned.
    always_comb begin
        if (st_byte_en == 4'b1111)
            wdata_aligned = st_data;
        else
            wdata_aligned = st_data << {st_addr[1:0], 3'b000};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= st_addr[31:2];
                data_q[wr_ptr] <= wdata_aligned;
                be_q[wr_ptr]   <= st_byte_en;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dm_req   = !sb_empty;
    assign dm_we    = dm_req;
    assign dm_addr  = dm_req ? {addr_q[rd_ptr], 2'b00} : '0;
    assign dm_wdata = dm_req ? data_q[rd_ptr] : '0;
    assign dm_be    = dm_req ? be_q[rd_ptr] : '0;

    // An entry is occupied when its distance from the head is below the count.
    always_comb begin
        word_hit = 1'b0;
        offs     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if (({1'b0, offs} < count) && (addr_q[i] == ld_addr[31:2]))
                word_hit = 1'b1;
        end
    end

    assign ld_hazard        = ld_valid && word_hit;
    assign unused_ld_offset = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: vector table with expected count/hazard per cycle,
// plus a scoreboard queue of expected memory writes checked against dm_*.
module tb_store_buffer;

    logic        i_clk;
    logic        i_rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_byte_en;
    logic        sb_full;
    logic        sb_empty;
    logic [2:0]  sb_count;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_we;
    logic        dm_ack;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte_en(st_byte_en),
        .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_we(dm_we),
        .dm_ack(dm_ack), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [3:0]  sbe;
        logic        ack;
        logic        lv;
        logic [31:0] la;
        int          cnt;
        logic        hz;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t  sb_q[$];
    vec_t vecs[23];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] align_exp(input logic [31:0] d, input logic [3:0] be);
        case (be)
            4'b1111: return d;
            4'b0011: return {16'h0, d[15:0]};
            4'b1100: return {d[15:0], 16'h0};
            4'b0001: return {24'h0, d[7:0]};
            4'b0010: return {16'h0, d[7:0], 8'h0};
            4'b0100: return {8'h0, d[7:0], 16'h0};
            4'b1000: return {d[7:0], 24'h0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Called at posedge+1; checks mid-cycle, then updates the model at the edge.
    task automatic step(input vec_t v);
        wr_t e;
        logic [31:0] m;
        st_valid = v.sv; st_addr = v.sa; st_data = v.sd; st_byte_en = v.sbe;
        dm_ack = v.ack; ld_valid = v.lv; ld_addr = v.la;
        @(negedge i_clk);
        chk("sb_count", 32'(sb_count), 32'(v.cnt));
        chk("model_count", 32'(sb_count), 32'(sb_q.size()));
        chk("sb_full", 32'(sb_full), 32'(v.cnt == 4));
        chk("sb_empty", 32'(sb_empty), 32'(v.cnt == 0));
        chk("dm_req", 32'(dm_req), 32'(v.cnt != 0));
        chk("dm_we", 32'(dm_we), 32'(v.cnt != 0));
        chk("ld_hazard", 32'(ld_hazard), 32'(v.hz));
        if (sb_q.size() != 0) begin
            m = lane_mask(sb_q[0].be);
            chk("dm_addr", dm_addr, sb_q[0].addr);
            chk("dm_be", 32'(dm_be), 32'(sb_q[0].be));
            chk("dm_wdata", dm_wdata & m, sb_q[0].data & m);
        end
        @(posedge i_clk);
        if (v.ack && sb_q.size() != 0)
            void'(sb_q.pop_front());
        if (v.sv && v.cnt < 4 && v.sbe != 4'b0000) begin
            e.addr = {v.sa[31:2], 2'b00};
            e.data = align_exp(v.sd, v.sbe);
            e.be   = v.sbe;
            sb_q.push_back(e);
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //           sv  addr          data          be       ack lv  ld_addr     cnt hz
        vecs[0]  = '{1, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0, 32'h0,   0, 0};
        vecs[1]  = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h102, 1, 1};
        vecs[2]  = '{0, 32'h0,   32'h0,        4'b0000, 0, 1, 32'h100, 0, 0};
        vecs[3]  = '{1, 32'h203, 32'h000000A5, 4'b1000, 0, 1, 32'h200, 0, 0};
        vecs[4]  = '{1, 32'h306, 32'h00001234, 4'b1100, 1, 1, 32'h200, 1, 1};
        vecs[5]  = '{1, 32'h500, 32'h12345678, 4'b0000, 0, 1, 32'h500, 1, 0};
        vecs[6]  = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h304, 1, 1};
        vecs[7]  = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h304, 0, 0};
        vecs[8]  = '{1, 32'h400, 32'h11111111, 4'b1111, 0, 0, 32'h0,   0, 0};
        vecs[9]  = '{1, 32'h411, 32'h00000022, 4'b0010, 0, 1, 32'h402, 1, 1};
        vecs[10] = '{1, 32'h420, 32'h00003333, 4'b0011, 0, 1, 32'h404, 2, 0};
        vecs[11] = '{1, 32'h43C, 32'h44444444, 4'b1111, 0, 0, 32'h400, 3, 0};
        vecs[12] = '{1, 32'h440, 32'h55555555, 4'b1111, 0, 1, 32'h43C, 4, 1};
        vecs[13] = '{1, 32'h440, 32'h55555555, 4'b1111, 1, 0, 32'h0,   4, 0};
        vecs[14] = '{1, 32'h440, 32'h55555555, 4'b1111, 0, 0, 32'h0,   3, 0};
        vecs[15] = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h440, 4, 1};
        vecs[16] = '{0, 32'h0,   32'h0,        4'b0000, 1, 0, 32'h0,   3, 0};
        vecs[17] = '{1, 32'h460, 32'h66666666, 4'b1111, 1, 0, 32'h0,   2, 0};
        vecs[18] = '{1, 32'h473, 32'h00000077, 4'b1000, 1, 0, 32'h0,   2, 0};
        vecs[19] = '{0, 32'h0,   32'h0,        4'b0000, 1, 0, 32'h0,   2, 0};
        vecs[20] = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h470, 1, 1};
        vecs[21] = '{0, 32'h0,   32'h0,        4'b0000, 0, 1, 32'h470, 0, 0};
        vecs[22] = '{0, 32'h0,   32'h0,        4'b0000, 0, 1, 32'h400, 0, 0};

        i_rst = 1'b0;
        st_valid = 0; st_addr = 0; st_data = 0; st_byte_en = 0;
        dm_ack = 0; ld_valid = 0; ld_addr = 0;
        #2;
        chk("rst_count", 32'(sb_count), 32'd0);
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_full", 32'(sb_full), 32'd0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        for (int k = 0; k < 23; k++)
            step(vecs[k]);

        // Asynchronous reset between edges with three writes pending.
        step('{1, 32'h600, 32'hA0A0A0A0, 4'b1111, 0, 0, 32'h0, 0, 0});
        step('{1, 32'h604, 32'hB0B0B0B0, 4'b1111, 0, 0, 32'h0, 1, 0});
        step('{1, 32'h608, 32'hC0C0C0C0, 4'b1111, 0, 0, 32'h0, 2, 0});
        st_valid = 0; dm_ack = 0; ld_valid = 1; ld_addr = 32'h604;
        #1;
        chk("pre_rst_count", 32'(sb_count), 32'd3);
        chk("pre_rst_hazard", 32'(ld_hazard), 32'd1);
        #1;
        i_rst = 1'b0;
        #1;
        chk("async_rst_dm_req", 32'(dm_req), 32'd0);
        chk("async_rst_count", 32'(sb_count), 32'd0);
        chk("async_rst_empty", 32'(sb_empty), 32'd1);
        chk("async_rst_hazard", 32'(ld_hazard), 32'd0);
        chk("async_rst_dm_be", 32'(dm_be), 32'd0);
        sb_q.delete();
        #2;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        step('{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h600, 0, 0});
        step('{0, 32'h0,   32'h0,        4'b0000, 0, 1, 32'h608, 0, 0});
        step('{1, 32'h700, 32'h77777777, 4'b1111, 0, 1, 32'h604, 0, 0});
        step('{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h604, 1, 0});
        step('{0, 32'h0,   32'h0,        4'b0000, 0, 1, 32'h700, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
